// File: rtl/alu_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// alu_ex_mem_stage
//
// Purpose: EX/MEM pipeline register directly behind the 64-bit ALU.
//   - Latches the ALU result, store data, destination and memory-control
//     bits into the MEM stage.
//   - Owns the architectural NZCV flag register. Only flag-setting
//     instructions (ANDS/ADDS/SUBS) update it.
//   - Provides a same-cycle NZCV bypass (cond_*) for B.cond resolution.
//   - Provides a latched zero bit (mem_zero) for CBZ in MEM.
//
// Ports:
//   clk, reset          clock (rising edge); asynchronous active-low reset
//   stall, flush        hold / squash the EX instruction (flush wins)
//   ex_*                EX-stage instruction: valid, result, NZCV, set_flags,
//                       rd, reg_write, mem_read, mem_write, store_data
//   mem_*               registered EX/MEM fields
//   flag_n/z/c/v        architectural NZCV register
//   cond_n/z/c/v        NZCV as seen by a condition check this cycle
// ---------------------------------------------------------------------------
module alu_ex_mem_stage #(
    parameter int WIDTH = 64,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             ex_negative,
    input  logic             ex_zero,
    input  logic             ex_carry,
    input  logic             ex_overflow,
    input  logic             ex_set_flags,
    input  logic [RADDR-1:0] ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic [WIDTH-1:0] ex_store_data,
    output logic             mem_valid,
    output logic [WIDTH-1:0] mem_result,
    output logic [WIDTH-1:0] mem_store_data,
    output logic [RADDR-1:0] mem_rd,
    output logic             mem_reg_write,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             mem_zero,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             cond_n,
    output logic             cond_z,
    output logic             cond_c,
    output logic             cond_v
);

    localparam logic [RADDR-1:0] XZR = '1;

    logic             valid_q,  valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] sdata_q,  sdata_d;
    logic [RADDR-1:0] rd_q,     rd_d;
    logic             regw_q,   regw_d;
    logic             mrd_q,    mrd_d;
    logic             mwr_q,    mwr_d;
    logic             zero_q,   zero_d;
    logic [3:0]       nzcv_q,   nzcv_d;   // {N,Z,C,V}

    logic [3:0] ex_nzcv;
    logic       ex_flag_wr;   // EX instruction is a live flag writer
    logic       capture;

    assign ex_nzcv    = {ex_negative, ex_zero, ex_carry, ex_overflow};
    assign ex_flag_wr = ex_valid & ex_set_flags & ~flush;
    assign capture    = ~stall & ~flush;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        sdata_d  = sdata_q;
        rd_d     = rd_q;
        regw_d   = regw_q;
        mrd_d    = mrd_q;
        mwr_d    = mwr_q;
        zero_d   = zero_q;
        nzcv_d   = nzcv_q;

        if (flush) begin
            // Bubble: kill valid and every side-effecting strobe; the data
            // fields are don't-care downstream so they simply hold.
            valid_d = 1'b0;
            regw_d  = 1'b0;
            mrd_d   = 1'b0;
            mwr_d   = 1'b0;
        end else if (capture) begin
            valid_d  = ex_valid;
            result_d = ex_result;
            sdata_d  = ex_store_data;
            rd_d     = ex_rd;
            zero_d   = ex_zero;
            // Writes to XZR are discarded here so the register file never
            // sees them.
            regw_d   = ex_valid & ex_reg_write & (ex_rd != XZR);
            mrd_d    = ex_valid & ex_mem_read;
            mwr_d    = ex_valid & ex_mem_write;
            if (ex_valid & ex_set_flags)
                nzcv_d = ex_nzcv;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            sdata_q  <= '0;
            rd_q     <= '0;
            regw_q   <= 1'b0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            zero_q   <= 1'b0;
            nzcv_q   <= 4'b0000;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            sdata_q  <= sdata_d;
            rd_q     <= rd_d;
            regw_q   <= regw_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
            zero_q   <= zero_d;
            nzcv_q   <= nzcv_d;
        end
    end

    assign mem_valid      = valid_q;
    assign mem_result     = result_q;
    assign mem_store_data = sdata_q;
    assign mem_rd         = rd_q;
    assign mem_reg_write  = regw_q;
    assign mem_mem_read   = mrd_q;
    assign mem_mem_write  = mwr_q;
    assign mem_zero       = zero_q;

    assign {flag_n, flag_z, flag_c, flag_v} = nzcv_q;

    // The EX instruction is the youngest flag writer even while stalled,
    // so stall does not gate the bypass; only a flush removes it.
    assign {cond_n, cond_z, cond_c, cond_v} = ex_flag_wr ? ex_nzcv : nzcv_q;

endmodule

// File: doc/alu_ex_mem_stage.md
Name: alu_ex_mem_stage

Overview:
Pipeline register sitting directly downstream of the 64-bit ALU (AND/ADD/SUB/etc. units) in the execute stage. Latches the ALU result, destination and memory-control bits into the EX/MEM boundary. Owns the architectural NZCV flag register, updated only by flag-setting instructions (ANDS/ADDS/SUBS). Provides a same-cycle flag bypass for B.cond resolution and a latched zero bit for CBZ.

Parameters:
WIDTH, 64, datapath width of the result and store data.
RADDR, 5, register-address width; the all-ones address (31) is XZR.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  hold the EX/MEM register and flags this cycle
flush  input  1  squash the EX instruction (insert bubble)
ex_valid  input  1  EX stage holds a real instruction
ex_result  input  WIDTH  ALU result
ex_negative  input  1  ALU N flag
ex_zero  input  1  ALU Z flag
ex_carry  input  1  ALU C flag
ex_overflow  input  1  ALU V flag
ex_set_flags  input  1  instruction writes NZCV
ex_rd  input  RADDR  destination register
ex_reg_write  input  1  instruction writes the register file
ex_mem_read  input  1  load
ex_mem_write  input  1  store
ex_store_data  input  WIDTH  store data
mem_valid  output  1  MEM stage holds a real instruction
mem_result  output  WIDTH  latched ALU result (memory address for loads/stores)
mem_store_data  output  WIDTH  latched store data
mem_rd  output  RADDR  latched destination
mem_reg_write  output  1  latched, qualified register write
mem_mem_read  output  1  latched load strobe
mem_mem_write  output  1  latched store strobe
mem_zero  output  1  latched ex_zero, for CBZ in MEM
flag_n, flag_z, flag_c, flag_v  output  1 each  architectural NZCV register
cond_n, cond_z, cond_c, cond_v  output  1 each  bypassed NZCV for condition evaluation this cycle

Behaviour:
- Reset (reset=0, asynchronous): every registered output is 0, including mem_valid, all mem_* fields, mem_zero and flag_n/z/c/v. Release is synchronous to the next clk edge. No capture occurs while reset=0.
- Latency: one cycle. EX inputs sampled on a clk edge appear on mem_* immediately after that edge.
- Per-edge priority is flush > stall > capture.
- flush=1, regardless of stall:
  - mem_valid, mem_reg_write, mem_mem_read and mem_mem_write go to 0.
  - mem_result, mem_store_data, mem_rd and mem_zero hold their values.
  - Flags are not updated.
- stall=1, flush=0: every mem_* output and every flag holds. The EX instruction is re-presented next cycle; no double update occurs.
- Capture (stall=0, flush=0):
  - mem_valid <= ex_valid.
  - mem_result, mem_store_data, mem_rd and mem_zero are loaded from the corresponding ex_* inputs.
  - Control bits are qualified by ex_valid:
    - mem_reg_write <= ex_valid & ex_reg_write & (ex_rd != all-ones). Writes to XZR are dropped here.
    - mem_mem_read <= ex_valid & ex_mem_read.
    - mem_mem_write <= ex_valid & ex_mem_write.
- Flag register: flag_* <= ex_* flags only when ex_valid & ex_set_flags & !stall & !flush. Otherwise the flags hold. Non-flag-setting instructions never alter NZCV.
- Bypass (combinational):
  - cond_* = ex_* flags when ex_valid & ex_set_flags & !flush.
  - Otherwise cond_* = flag_*.
  - stall does not block the bypass; the stalled EX instruction is still the youngest flag writer.
- ex_mem_read and ex_mem_write both asserted is illegal. It is latched as-is; a bench assertion flags it.
- Widths are straight copies. No arithmetic is performed in this block.

Test Plan:
- Reset mid-stream: drive a valid capture, then pulse reset=0 between clk edges -> all outputs read 0 immediately and stay 0 until the first edge after release.
- Capture: ex_valid=1, ex_result=64'h0000_0000_0000_00F0, ex_rd=3, ex_reg_write=1 -> one edge later mem_result=0xF0, mem_rd=3, mem_reg_write=1, mem_valid=1.
- ANDS setting flags: ex_result=0, ex_zero=1, ex_set_flags=1 -> cond_z=1 in the same cycle, flag_z=1 after the edge. A following instruction with ex_set_flags=0 and ex_zero=0 leaves flag_z=1.
- Stall then flush: set_flags instruction with ex_negative=1 and stall=1 for 2 cycles -> mem_* and flag_n unchanged, cond_n=1 throughout. Then flush=1 with stall=1 -> mem_valid=0, flag_n still 0.
- XZR write: ex_rd=31, ex_reg_write=1, ex_valid=1 -> mem_reg_write=0, mem_rd=31, mem_valid=1.
- Bubble: ex_valid=0 with ex_mem_write=1 and ex_set_flags=1 -> mem_mem_write=0, mem_valid=0, flags unchanged, cond_* equals flag_*.
